// File: rtl/moment_ram_arbiter_pkg.sv
// moment_ram_pkg: shared types and constants for the moment RAM arbiter.
// Contents: default RAM geometry, arbiter state enum, requester indices.
package moment_ram_pkg;

    localparam int unsigned DEPTH_DEF      = 256;   // 16*16 lattice
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic {
        ARB_CLEAR = 1'b0,
        ARB_RUN   = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_ENGINE  = 0;
    localparam int unsigned REQ_DISPLAY = 1;

endpackage

// File: rtl/moment_ram_arbiter_if.sv
// moment_ram_arbiter_if: request/response and RAM-side bundle of the arbiter.
// Requester side: req, we, addr0/1, wdata0/1 -> gnt, rvalid, rdata, init_done.
// RAM side:       ram_address, ram_we, ram_wdata -> moment_ram; ram_rdata back.
// master = requesters plus RAM model, slave = the arbiter.
interface moment_ram_arbiter_if
    import moment_ram_pkg::*;
#(
    parameter int unsigned DEPTH         = DEPTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
);
    logic [1:0]                    req;
    logic [1:0]                    we;
    logic [ADDRESS_WIDTH-1:0]      addr0;
    logic [ADDRESS_WIDTH-1:0]      addr1;
    logic signed [DATA_WIDTH-1:0]  wdata0;
    logic signed [DATA_WIDTH-1:0]  wdata1;
    logic [1:0]                    gnt;
    logic [1:0]                    rvalid;
    logic signed [DATA_WIDTH-1:0]  rdata;
    logic                          init_done;
    logic [ADDRESS_WIDTH-1:0]      ram_address;
    logic                          ram_we;
    logic signed [DATA_WIDTH-1:0]  ram_wdata;
    logic signed [DATA_WIDTH-1:0]  ram_rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt, rvalid, rdata, init_done, ram_address, ram_we, ram_wdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt, rvalid, rdata, init_done, ram_address, ram_we, ram_wdata
    );
endinterface

// File: rtl/moment_ram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant logic (purely combinational).
// Inputs:  req[1:0] requests, prio (1 = requester 1 wins a tie), en.
// Outputs: gnt[1:0] one-hot or zero, prio_next (toggles only on a tie).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       prio_next
);
    always_comb begin
        gnt       = '0;
        prio_next = prio;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    gnt       = prio ? 2'b10 : 2'b01;
                    prio_next = ~prio;
                end
                default: gnt = '0;
            endcase
        end
    end
endmodule

// File: rtl/moment_ram_arbiter.sv
// moment_ram_arbiter: shares one single-port moment_ram between the lattice
// engine (requester 0) and the display path (requester 1).
// Ports: Clk, Reset_n (synchronous, active-low), bus (moment_ram_arbiter_if.slave).
// Optional feature: define MOMENT_ARB_CLEAR_EN to zero the whole RAM after
// reset before any request is granted; otherwise arbitration starts at once.
// Read data is registered: rvalid[i] pulses one cycle after a read grant.
module moment_ram_arbiter
    import moment_ram_pkg::*;
#(
    parameter int unsigned DEPTH         = DEPTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    moment_ram_arbiter_if.slave   bus
);
    arb_state_t                   state, state_next;
    logic                         prio, prio_next;
    logic                         arb_en;
    logic [1:0]                   gnt, rd_gnt;
    logic [1:0]                   rvalid_q;
    logic signed [DATA_WIDTH-1:0] rdata_q;
    logic [ADDRESS_WIDTH-1:0]     addr_mux;
    logic signed [DATA_WIDTH-1:0] wdata_mux;
    logic                         we_mux;

`ifdef MOMENT_ARB_CLEAR_EN
    logic [ADDRESS_WIDTH-1:0]     clr_addr;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= ARB_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_CLEAR)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ARB_CLEAR && clr_addr == ADDRESS_WIDTH'(DEPTH - 1))
            state_next = ARB_RUN;
    end
`else
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= ARB_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
    end
`endif

    // Reset gating here is what forces gnt (and hence ram_we) low combinationally.
    assign arb_en = Reset_n && (state == ARB_RUN);

    rr_arb2 u_rr_arb2 (
        .req       (bus.req),
        .prio      (prio),
        .en        (arb_en),
        .gnt       (gnt),
        .prio_next (prio_next)
    );

    always_comb begin
        addr_mux  = bus.addr0;
        wdata_mux = bus.wdata0;
        we_mux    = 1'b0;
        if (gnt[REQ_DISPLAY]) begin
            addr_mux  = bus.addr1;
            wdata_mux = bus.wdata1;
            we_mux    = bus.we[REQ_DISPLAY];
        end else if (gnt[REQ_ENGINE]) begin
            we_mux    = bus.we[REQ_ENGINE];
        end
`ifdef MOMENT_ARB_CLEAR_EN
        if (Reset_n && state == ARB_CLEAR) begin
            addr_mux  = clr_addr;
            wdata_mux = '0;
            we_mux    = 1'b1;
        end
`endif
    end

    assign rd_gnt = gnt & ~bus.we;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prio     <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            prio     <= prio_next;
            rvalid_q <= rd_gnt;
            if (|rd_gnt)
                rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.init_done   = arb_en;
    assign bus.ram_address = addr_mux;
    assign bus.ram_wdata   = wdata_mux;
    assign bus.ram_we      = we_mux;
endmodule

// File: tb/tb_moment_ram_arbiter.sv
// tb_moment_ram_arbiter: directed plus randomized bench for moment_ram_arbiter.
// Contains a behavioural moment_ram (combinational read, clocked write) and a
// reference model built from the arbitration rules (tie winner alternates).
// Works with or without MOMENT_ARB_CLEAR_EN defined.
module tb_moment_ram_arbiter;
    import moment_ram_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 8;
`ifdef MOMENT_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    moment_ram_arbiter_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    moment_ram_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // RAM attached to the arbiter
    logic [DW-1:0] mem [DEPTH];
    always @(posedge Clk) begin
        if (bus.ram_we === 1'b1)
            mem[bus.ram_address] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_address];

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            favour;          // requester that wins the next tie
    logic [1:0]    exp_rvalid;
    logic [DW-1:0] exp_rdata;
    int unsigned   sweep;
    bit            run_m;

    // Stimulus registers
    logic [1:0]    r_req, r_we;
    logic [AW-1:0] r_addr0, r_addr1;
    logic [DW-1:0] r_wd0, r_wd1;
    logic [1:0]    seen_gnt, last_eg;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of traffic: drive at the falling edge, check, advance model.
    task automatic cycle();
        logic [1:0]    eg, rd;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bus.req = r_req; bus.we = r_we;
        bus.addr0 = r_addr0; bus.addr1 = r_addr1;
        bus.wdata0 = r_wd0; bus.wdata1 = r_wd1;
        #1;
        if (!run_m) begin
            eg = 2'b00; ewe = 1'b1; ea = AW'(sweep); ed = '0;
        end else begin
            if (r_req == 2'b11) eg = favour ? 2'b10 : 2'b01;
            else                eg = r_req;
            if (eg == 2'b10)      begin ewe = r_we[1]; ea = r_addr1; ed = r_wd1; end
            else if (eg == 2'b01) begin ewe = r_we[0]; ea = r_addr0; ed = r_wd0; end
            else                  begin ewe = 1'b0;    ea = r_addr0; ed = r_wd0; end
        end
        seen_gnt = bus.gnt;
        chk("gnt", bus.gnt, eg);
        chk("ram_we", bus.ram_we, ewe);
        chk("ram_address", bus.ram_address, ea);
        if (ewe) chk("ram_wdata", bus.ram_wdata, ed);
        chk("rvalid", bus.rvalid, exp_rvalid);
        chk("rdata", bus.rdata, exp_rdata);
        chk("init_done", bus.init_done, run_m);
        rd = eg & ~r_we;
        if (rd != 2'b00) exp_rdata = ref_mem[ea];
        if (ewe) ref_mem[ea] = ed;
        if (run_m && r_req == 2'b11) favour = !favour;
        exp_rvalid = rd;
        last_eg = eg;
        if (!run_m) begin
            sweep++;
            if (sweep == DEPTH) run_m = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Hold reset for two edges with requests pending; called at a falling edge.
    task automatic do_reset();
        bus.req = 2'b11; bus.we = 2'b11;
        Reset_n = 1'b0;
        #1;
        chk("rst_gnt_comb", bus.gnt, 2'b00);
        chk("rst_we_comb", bus.ram_we, 1'b0);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_rvalid", bus.rvalid, 2'b00);
        chk("rst_rdata", bus.rdata, '0);
        chk("rst_init_done", bus.init_done, 1'b0);
        Reset_n    = 1'b1;
        favour     = 1'b0;
        exp_rvalid = 2'b00;
        exp_rdata  = '0;
        sweep      = 0;
        run_m      = !CLR_EN;
    endtask

    initial begin
        bit [1:0] pend;
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        r_req = '0; r_we = '0; r_addr0 = '0; r_addr1 = '0; r_wd0 = '0; r_wd1 = '0;
        @(negedge Clk);
        do_reset();

        // Reads of 3 and 4 held through the sweep, then alternate 01,10,01,10
        r_req = 2'b11; r_we = 2'b00; r_addr0 = 8'd3; r_addr1 = 8'd4;
        guard = 0;
        while (!run_m && guard < DEPTH + 8) begin
            cycle();
            guard++;
        end
        chk("sweep_len", guard, CLR_EN ? DEPTH : 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("tie_seq", seen_gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
        end
        r_req = 2'b00;
        cycle();

        // Engine writes -5 to 17, display reads 17 the next cycle
        r_req = 2'b01; r_we = 2'b01; r_addr0 = 8'd17; r_wd0 = 32'hFFFF_FFFB;
        cycle();
        r_req = 2'b10; r_we = 2'b00; r_addr1 = 8'd17;
        cycle();
        chk("wr_rd_gnt", seen_gnt, 2'b10);
        chk("wr_rd_rvalid", bus.rvalid, 2'b10);
        chk("wr_rd_rdata", bus.rdata, 32'hFFFF_FFFB);
        r_req = 2'b00;
        cycle();

        // Read of 37: cleared or still the power-up pattern
        r_req = 2'b01; r_we = 2'b00; r_addr0 = 8'd37;
        cycle();
        chk("rd37", bus.rdata, CLR_EN ? 32'h0 : 32'h1000_0025);
        r_req = 2'b00;
        cycle();

        // Display alone for 3 cycles, then a tie still goes to the engine
        r_req = 2'b10; r_we = 2'b00; r_addr1 = 8'd5;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("solo_gnt", seen_gnt, 2'b10);
        end
        r_req = 2'b11;
        cycle();
        chk("prio_kept", seen_gnt, 2'b01);
        r_req = 2'b00;
        cycle();

        // Random traffic, requests held until granted or occasionally withdrawn
        pend = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        pend[i] = 1'b1;
                        r_we[i] = 1'($urandom_range(0, 1));
                        if (i == 0) begin
                            r_addr0 = AW'($urandom_range(0, 15));
                            r_wd0   = $urandom;
                        end else begin
                            r_addr1 = AW'($urandom_range(0, 15));
                            r_wd1   = $urandom;
                        end
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            r_req = pend;
            cycle();
            pend = pend & ~last_eg;
        end
        r_req = 2'b00;
        cycle();

        // Reset in the middle of the sweep (or of operation) restarts cleanly
        do_reset();
        for (int k = 0; k < 100; k++) cycle();
        do_reset();
        guard = 0;
        while (!run_m && guard < DEPTH + 8) begin
            cycle();
            guard++;
        end
        chk("resweep_len", guard, CLR_EN ? DEPTH : 0);
        r_req = 2'b11; r_we = 2'b00; r_addr0 = 8'd100; r_addr1 = 8'd101;
        cycle();
        chk("post_rst_tie", seen_gnt, 2'b01);
        r_req = 2'b00;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/moment_ram_arbiter.md
# moment_ram_arbiter

Two-port round-robin arbiter and initialiser that shares one single-port `moment_ram` (DEPTH words, signed DATA_WIDTH) between the lattice update engine (requester 0) and the display/readout path (requester 1). After reset it optionally sweeps the whole RAM to zero. It then grants at most one access per cycle and returns read data one cycle after the grant. It sits between the LBM engine, the readout logic and the RAM ports (`address`, `WE`, `data_in`, `data_out`).

## Interface
- DEPTH, 256 (16*16): RAM words; must match the attached `moment_ram`.
- ADDRESS_WIDTH, $clog2(DEPTH): address width.
- DATA_WIDTH, 32: signed data width.

Ports:
- Clk  in  1  system clock; everything is on the rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- req  in  [1:0]  request per requester; held high until granted.
- we  in  [1:0]  1 = write, 0 = read; per requester, stable while req is high.
- addr0, addr1  in  ADDRESS_WIDTH each  access address per requester.
- wdata0, wdata1  in  signed DATA_WIDTH  write data per requester.
- gnt  out  [1:0]  one-hot or zero; the access is performed in the cycle gnt is high.
- rvalid  out  [1:0]  read data valid for requester i.
- rdata  out  signed DATA_WIDTH  registered read data, shared by both requesters and qualified by rvalid.
- init_done  out  1  high once the clear sweep has finished.
- ram_address  out  ADDRESS_WIDTH  to `moment_ram.address`.
- ram_we  out  1  to `moment_ram.WE`.
- ram_wdata  out  signed DATA_WIDTH  to `moment_ram.data_in`.
- ram_rdata  in  signed DATA_WIDTH  from `moment_ram.data_out`, which is a combinational read.

## Operation
- FSM states: ARB_CLEAR and ARB_RUN.
  - Reset goes to ARB_CLEAR.
  - ARB_CLEAR goes to ARB_RUN when clr_addr == DEPTH-1.
  - ARB_RUN has no exit except reset.
- ARB_CLEAR:
  - ram_we = 1, ram_address = clr_addr, ram_wdata = 0.
  - clr_addr increments from 0 each cycle.
  - gnt = 0 and init_done = 0.
  - Requests stay pending; they are not dropped.
- ARB_RUN:
  - init_done = 1.
  - If exactly one req bit is set, that requester is granted.
  - If both are set, the requester selected by prio is granted.
  - prio (1 bit) flips to the other requester after every grant that occurs while both were requesting. A sole grant leaves prio unchanged.
  - gnt is combinational from req, prio and state.
  - The RAM-side ports are a combinational mux of the granted requester: ram_we = we[i] & gnt[i].
  - With no grant, ram_we = 0 and ram_address = addr0.
- Read path:
  - On a read grant to i, rdata <= ram_rdata and rvalid[i] <= 1 at the next edge.
  - rvalid is a 1-cycle pulse.
  - rdata holds its value until the next read grant.
- Writes produce no rvalid.
- Reset values: prio = 0 (requester 0 favoured), clr_addr = 0, rvalid = 0, rdata = 0, init_done = 0.
- While Reset_n is low: gnt = 0 and ram_we = 0, forced combinationally.
- Reset asserted mid-sweep or mid-operation: the sweep restarts at address 0. A read in flight loses its rvalid.
- A requester deasserting req before grant: the request is withdrawn and prio is unaffected.

## Timing
- Grant latency in ARB_RUN:
  - 0 cycles when uncontended or when holding prio.
  - At most 1 cycle when contended.
  - A held request is never starved beyond 1 cycle.
- Read latency: rvalid[i] is asserted 1 cycle after gnt[i].
- Throughput: 1 access per cycle. Back-to-back grants to the same requester are allowed.
- Write and then read of the same address in consecutive cycles returns the new data.
- Clear sweep lasts exactly DEPTH cycles after Reset_n is released. init_done rises on the edge that ends the sweep.

## Configuration
- MOMENT_ARB_CLEAR_EN defined: ARB_CLEAR sweep is present as described.
- Not defined:
  - Reset goes directly to ARB_RUN.
  - init_done = 1 from the first cycle after Reset_n is released.
  - clr_addr logic is absent.
  - RAM contents after power-up are undefined.

## Structure
- Package `moment_ram_pkg`:
  - Default DEPTH and DATA_WIDTH constants.
  - `arb_state_t` enum {ARB_CLEAR, ARB_RUN}.
  - Requester index constants REQ_ENGINE = 0 and REQ_DISPLAY = 1.
- Sub-module `rr_arb2`:
  - Inputs req[1:0], prio, en. Outputs gnt[1:0] (combinational) and prio_next.
- The arbiter does not instantiate `moment_ram`; the parent wires ram_* to it.

## Test plan
- Reset release with MOMENT_ARB_CLEAR_EN defined:
  - ram_we = 1 with addresses 0..255 and data 0 for 256 cycles.
  - init_done rises on cycle 256.
  - A read of address 37 afterwards returns 0.
- Requester 0 writes -5 to address 17, then requester 1 reads 17 on the next cycle -> gnt1 in the same cycle, rvalid[1] one cycle later, rdata = -5 (0xFFFFFFFB).
- Both requesters hold reads of addresses 3 and 4 for 4 cycles after reset (prio = 0) -> gnt sequence 01, 10, 01, 10; rvalid follows one cycle later each time.
- Requester 1 alone holds req for 3 cycles -> granted every cycle, and prio stays 0.
- Requests asserted during ARB_CLEAR -> no gnt until init_done = 1, then granted in the first ARB_RUN cycle.
- Reset_n pulsed low at sweep address 100 -> sweep restarts at 0; init_done = 0 until a full 256-cycle sweep completes.
